// File: rtl/game_pkg.sv
// game_pkg: shared types and default tuning values for the game flow logic.
//   seq_state_t  : level_sequencer state, also exported as the 3-bit phase
//                  value read by the HUD and renderer.
//   DEF_*        : default parameter values for level_sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_PLAY       = 3'd2,
    ST_DEATH_WAIT = 3'd3,
    ST_WIN_WAIT   = 3'd4,
    ST_GAME_OVER  = 3'd5,
    ST_COMPLETE   = 3'd6
  } seq_state_t;

  localparam int DEF_NUM_LEVELS   = 4;
  localparam int DEF_START_LIVES  = 3;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_WIN_FRAMES   = 90;

endpackage

// File: rtl/pause_timer.sv
// pause_timer: counts frame_tick pulses while a pause is in progress.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : hold the count at zero (high whenever no pause is running)
//   frame_tick  : one-cycle pulse per video frame
//   target      : number of frame ticks the pause lasts (>= 1)
//   done        : one-cycle pulse on the frame_tick that finds count == target-1
module pause_timer #(
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               frame_tick,
  input  logic [FRAME_W-1:0] target,
  output logic               done
);

  logic [FRAME_W-1:0] count_q;

  // done is combinational so the sequencer leaves the pause on the very
  // frame_tick edge that completes it.
  assign done = frame_tick & ~clear & (count_q == target - FRAME_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || done) begin
      count_q <= '0;
    end else if (frame_tick) begin
      count_q <= count_q + FRAME_W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: top-level game flow controller above game_state.
// Sequences title, level load, play, death/win pauses, game over and
// game complete; owns the lives counter and level index and drives the
// game_state reset.
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   start_btn      : synchronized start/confirm button level
//   dead, win      : status from game_state (only honoured in PLAY)
//   gs_rst_n       : registered active-low reset to game_state
//   load_level     : one-cycle pulse telling loaders to fetch level_idx
//   level_idx      : current level
//   lives          : remaining lives
//   phase          : current state encoding for HUD/renderer
//   game_over      : high in GAME_OVER
//   game_complete  : high in COMPLETE
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS   = DEF_NUM_LEVELS,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int WIN_FRAMES   = DEF_WIN_FRAMES,
  parameter int LEVEL_W      = 2,
  parameter int LIVES_W      = 3,
  parameter int FRAME_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               dead,
  input  logic               win,
  output logic               gs_rst_n,
  output logic               load_level,
  output logic [LEVEL_W-1:0] level_idx,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         phase,
  output logic               game_over,
  output logic               game_complete
);

  seq_state_t         state;
  logic               start_q;
  logic               start_edge;
  logic               pause_clear;
  logic               pause_done;
  logic [FRAME_W-1:0] pause_target;

  assign start_edge = start_btn & ~start_q;
  assign phase      = state;

  // The timer only runs inside the two pause states; everywhere else it is
  // held at zero, so entering a pause always starts from a fresh count.
  assign pause_clear  = (state != ST_DEATH_WAIT) && (state != ST_WIN_WAIT);
  assign pause_target = (state == ST_WIN_WAIT) ? FRAME_W'(WIN_FRAMES)
                                               : FRAME_W'(DEATH_FRAMES);

  pause_timer #(
    .FRAME_W (FRAME_W)
  ) u_pause_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pause_clear),
    .frame_tick (frame_tick),
    .target     (pause_target),
    .done       (pause_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_btn;
    end
  end

  // Outputs are assigned on each transition from the state being entered,
  // so they line up with phase: gs_rst_n is low in every cycle showing
  // LOAD and high from the first PLAY cycle, load_level is high exactly
  // while phase shows LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      level_idx     <= '0;
      lives         <= LIVES_W'(START_LIVES);
      gs_rst_n      <= 1'b0;
      load_level    <= 1'b0;
      game_over     <= 1'b0;
      game_complete <= 1'b0;
    end else begin
      load_level <= 1'b0;
      case (state)
        ST_IDLE: begin
          gs_rst_n <= 1'b0;
          if (start_edge) begin
            lives      <= LIVES_W'(START_LIVES);
            level_idx  <= '0;
            load_level <= 1'b1;
            state      <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          gs_rst_n <= 1'b1;
          state    <= ST_PLAY;
        end

        ST_PLAY: begin
          // dead wins over win when both arrive together
          if (dead) begin
            if (lives != '0) begin
              lives <= lives - LIVES_W'(1);
            end
            state <= ST_DEATH_WAIT;
          end else if (win) begin
            state <= ST_WIN_WAIT;
          end
        end

        ST_DEATH_WAIT: begin
          if (pause_done) begin
            gs_rst_n <= 1'b0;
            if (lives == '0) begin
              game_over <= 1'b1;
              state     <= ST_GAME_OVER;
            end else begin
              load_level <= 1'b1;
              state      <= ST_LOAD;
            end
          end
        end

        ST_WIN_WAIT: begin
          if (pause_done) begin
            gs_rst_n <= 1'b0;
            if (level_idx == LEVEL_W'(NUM_LEVELS - 1)) begin
              game_complete <= 1'b1;
              state         <= ST_COMPLETE;
            end else begin
              level_idx  <= level_idx + LEVEL_W'(1);
              load_level <= 1'b1;
              state      <= ST_LOAD;
            end
          end
        end

        ST_GAME_OVER, ST_COMPLETE: begin
          gs_rst_n <= 1'b0;
          if (start_edge) begin
            lives         <= LIVES_W'(START_LIVES);
            level_idx     <= '0;
            game_over     <= 1'b0;
            game_complete <= 1'b0;
            load_level    <= 1'b1;
            state         <= ST_LOAD;
          end
        end

        default: begin
          // unused encoding: recover to the title screen
          state         <= ST_IDLE;
          gs_rst_n      <= 1'b0;
          game_over     <= 1'b0;
          game_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Top-level game flow controller above game_state.
- Sequences title screen, level load, play, death/win pause, game-over and game-complete.
- Owns the lives counter and level index, and drives the game_state reset.
- Sits between the input/HUD logic and game_state; the renderer reads phase/level/lives.

Parameters:
- NUM_LEVELS, 4, number of levels; index 0..NUM_LEVELS-1
- START_LIVES, 3, lives at game start (1..2^LIVES_W-1)
- DEATH_FRAMES, 60, frame_tick pulses spent in death pause (>=1)
- WIN_FRAMES, 90, frame_tick pulses spent in level-clear pause (>=1)
- LEVEL_W, 2, width of level_idx; 2^LEVEL_W >= NUM_LEVELS
- LIVES_W, 3, width of lives
- FRAME_W, 8, pause counter width; 2^FRAME_W > max(DEATH_FRAMES, WIN_FRAMES)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- start_btn  in  1  synchronized start/confirm button level
- dead  in  1  from game_state: player dead
- win  in  1  from game_state: level complete
- gs_rst_n  out  1  registered active-low reset to game_state
- load_level  out  1  one-cycle pulse: map/sprite loaders fetch level_idx
- level_idx  out  LEVEL_W  current level
- lives  out  LIVES_W  remaining lives
- phase  out  3  current state encoding for HUD/renderer
- game_over  out  1  high in GAME_OVER
- game_complete  out  1  high in COMPLETE

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered.
  - Async reset: state=IDLE, level_idx=0, lives=START_LIVES, gs_rst_n=0, load_level=0, game_over=0, game_complete=0, pause counter=0, start edge register=0.
- Start edge:
  - start_edge = start_btn & ~start_q, where start_q is start_btn registered each cycle.
  - Holding the button produces one edge only.
- State encoding (phase value): IDLE=0, LOAD=1, PLAY=2, DEATH_WAIT=3, WIN_WAIT=4, GAME_OVER=5, COMPLETE=6.
- IDLE:
  - gs_rst_n=0.
  - On start_edge: lives=START_LIVES, level_idx=0, go to LOAD.
- LOAD (exactly 1 cycle):
  - gs_rst_n=0 and load_level=1 are both registered, so both are visible the cycle after entry.
  - Next state is PLAY.
- PLAY:
  - gs_rst_n=1.
  - dead has priority over win when both are sampled high in the same cycle.
  - dead: lives decrements on the transition edge; pause counter=0; go to DEATH_WAIT.
  - win (and not dead): pause counter=0; go to WIN_WAIT.
  - frame_tick and start_btn are ignored.
- DEATH_WAIT:
  - gs_rst_n stays 1, so game_state holds DEAD for the renderer.
  - Counter increments on each frame_tick.
  - On a frame_tick with counter==DEATH_FRAMES-1: if lives==0 go to GAME_OVER, else go to LOAD (same level_idx).
- WIN_WAIT:
  - Counter increments on each frame_tick.
  - On a frame_tick with counter==WIN_FRAMES-1: if level_idx==NUM_LEVELS-1 go to COMPLETE, else level_idx+1 and go to LOAD.
- GAME_OVER / COMPLETE:
  - gs_rst_n=0; game_over / game_complete=1 respectively.
  - On start_edge: lives=START_LIVES, level_idx=0, go to LOAD.
- Invariants:
  - lives never wraps below 0; a decrement only occurs in PLAY, where lives>=1.
  - level_idx never exceeds NUM_LEVELS-1.
- dead/win are ignored outside PLAY. This includes the stale values game_state shows during pauses.
- Reset asserted mid-operation (any state) returns to IDLE values immediately; no pulse of load_level is emitted.
- Illegal phase encoding (7) goes to IDLE on the next clock.

Decomposition:
- Package game_pkg: seq_state_t enum (3-bit, values above), NUM_LEVELS, START_LIVES, DEATH_FRAMES, WIN_FRAMES defaults. game_state later migrates its state_t into this package.
- One sub-module, pause_timer:
  - Inputs: clk, rst_n, clear, frame_tick, target.
  - Output: done, a 1-cycle pulse on the frame_tick that reaches target-1.
  - Instantiated once; target is muxed between DEATH_FRAMES and WIN_FRAMES by state.
- FSM, lives and level registers stay in level_sequencer.

Test Plan:
- Power-up and start: hold rst_n=0 for 3 cycles, release, then pulse start_btn -> phase 0→1→2; load_level high exactly 1 cycle; gs_rst_n low during LOAD, high in PLAY; level_idx=0; lives=3.
- Death with lives left: in PLAY assert dead, with DEATH_FRAMES=4 -> lives=2 the cycle after; phase=3; exits to LOAD on the 4th frame_tick exactly, not on the 3rd; level_idx stays 0.
- Game over: START_LIVES=1, die once -> after 4 ticks phase=5, game_over=1, gs_rst_n=0. A start_btn held high 10 cycles -> single restart, lives=1, level_idx=0.
- Level progression and completion: NUM_LEVELS=2, WIN_FRAMES=3, win in level 0 -> level_idx=1 after 3 ticks plus one load_level pulse. Win again -> phase=6, game_complete=1, level_idx stays 1.
- Simultaneous dead and win in PLAY -> DEATH_WAIT taken, lives decremented, level_idx unchanged. dead/win pulsed in IDLE, GAME_OVER or the WAIT states -> no state change.
- Async reset during WIN_WAIT at counter=2 -> outputs take reset values without waiting for a clock edge; phase=0; no load_level pulse.
